muldiv_sequencer: RTL and testbench

Iterative unsigned multiply/divide engine and owner of the architectural HI/LO registers.
- Decode raises start (from the ToLH decode signal) together with op_div (DIVU = 1, MULTU = 0) and the two register operands.
- The block runs a one-bit-per-cycle shift-add or restoring-divide sequence, then writes HI/LO.
- It stalls the pipeline while a new multiply/divide, MFHI or MFLO would collide with an operation in flight.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_sequencer.sv | 126 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide sequencer
package muldiv_pkg;

  // Default operand/HI/LO width
  localparam int MULDIV_WIDTH = 32;

  // Widest datapath the divide-by-zero constant can cover
  localparam int MULDIV_MAX_WIDTH = 64;

  // LO value written for a divide by zero (all-ones, sliced to WIDTH by users)
  localparam logic [MULDIV_MAX_WIDTH-1:0] DIV0_LO = '1;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration of shift-add multiply or restoring divide
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             op_div,
  input  logic [WIDTH-1:0] upper,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] upper_nxt,
  output logic [WIDTH-1:0] lower_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Multiply adds the multiplicand into the high half when the LSB is set and
  // shifts right with carry into the MSB. Divide shifts the remainder/quotient
  // pair left; the shifted remainder keeps its top bit so a remainder at or
  // above 2^(WIDTH-1) still compares correctly. When the subtraction succeeds
  // the true difference is below the divisor, so WIDTH bits hold it exactly.
  always_comb begin
    sum       = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
    rem_sh    = {upper, lower[WIDTH-1]};
    ge        = (rem_sh >= {1'b0, operand});
    diff      = rem_sh[WIDTH-1:0] - operand;
    upper_nxt = '0;
    lower_nxt = '0;
    if (op_div) begin
      upper_nxt = ge ? diff : rem_sh[WIDTH-1:0];
      lower_nxt = {lower[WIDTH-2:0], ge};
    end else begin
      upper_nxt = sum[WIDTH:1];
      lower_nxt = {sum[0], lower[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULTU/DIVU engine owning HI/LO with decode stall
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] upper_q, upper_d;
  logic [WIDTH-1:0] lower_q, lower_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_upper;
  logic [WIDTH-1:0] step_lower;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op_div   (state_q == ST_DIV),
    .upper    (upper_q),
    .lower    (lower_q),
    .operand  (opnd_q),
    .upper_nxt(step_upper),
    .lower_nxt(step_lower)
  );

  // Next-state logic: accept starts in IDLE/DONE, iterate in MUL/DIV, and
  // commit HI/LO only on the final step or the divide-by-zero fast path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    upper_d = upper_q;
    lower_d = lower_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          cnt_d   = CNT_W'(WIDTH - 1);
          upper_d = '0;
          if (!op_div) begin
            state_d = ST_MUL;
            lower_d = src_b;
            opnd_d  = src_a;
          end else if (src_b != '0) begin
            state_d = ST_DIV;
            lower_d = src_a;
            opnd_d  = src_b;
          end else begin
            state_d = ST_DONE;
            hi_d    = src_a;
            lo_d    = DIV0_LO[WIDTH-1:0];
            done_d  = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        upper_d = step_upper;
        lower_d = step_lower;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          hi_d    = step_upper;
          lo_d    = step_lower;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, working registers and architectural HI/LO; reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      upper_q <= '0;
      lower_q <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Decode must hold a new MULTU/DIVU or an MFHI/MFLO while iterating
  always_comb begin
    busy  = (state_q == ST_MUL) || (state_q == ST_DIV);
    stall = busy && (start || rd_hilo);
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam int W     = 32;
  localparam int LIMIT = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_div = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         rd_hilo = 1'b0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int vec = 0;
  int err = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div),
    .src_a(src_a), .src_b(src_b), .rd_hilo(rd_hilo),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} from plain arithmetic
  function automatic logic [2*W-1:0] ref_model(input logic div, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    if (!div) r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    else if (b == '0) r = {a, {W{1'b1}}};
    else r = {a % b, a / b};
    return r;
  endfunction

  // Present one start for a single cycle; returns just after the next falling edge
  task automatic issue(input logic div, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op_div = div; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // Count sample points until done, and how many of them saw busy
  task automatic wait_done(output int n, output int nbusy);
    n = 0; nbusy = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vec++; if ({hi, lo} !== '0) begin err++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    vec++; if ({busy, stall, done} !== 3'b000) begin err++; $display("FAIL reset_flags: got %b want 000", {busy, stall, done}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul_basic;
    int n, nb;
    issue(1'b0, 32'd7, 32'd6);
    wait_done(n, nb);
    vec++; if (n !== W) begin err++; $display("FAIL mul7x6_latency: got %0d want %0d", n, W); end
    vec++; if (nb !== W) begin err++; $display("FAIL mul7x6_busy_cycles: got %0d want %0d", nb, W); end
    vec++; if (hi !== 32'h0 || lo !== 32'h2A) begin err++; $display("FAIL mul7x6_result: got %h_%h want 00000000_0000002a", hi, lo); end
    @(negedge clk); #1;
    vec++; if (done !== 1'b0) begin err++; $display("FAIL mul7x6_done_pulse: got %b want 0", done); end
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, nb);
    vec++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin err++; $display("FAIL mul_max_result: got %h_%h want fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_div_basic;
    int n, nb;
    issue(1'b1, 32'd100, 32'd7);
    wait_done(n, nb);
    vec++; if (n !== W) begin err++; $display("FAIL div100_7_latency: got %0d want %0d", n, W); end
    vec++; if (lo !== 32'd14 || hi !== 32'd2) begin err++; $display("FAIL div100_7_result: got hi=%0d lo=%0d want hi=2 lo=14", hi, lo); end
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, nb);
    vec++; if (lo !== 32'h0 || hi !== 32'h8000_0000) begin err++; $display("FAIL div_big_result: got %h_%h want 80000000_00000000", hi, lo); end
    issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    wait_done(n, nb);
    vec++; if (lo !== 32'h1 || hi !== 32'h7FFF_FFFE) begin err++; $display("FAIL div_wide_rem: got %h_%h want 7ffffffe_00000001", hi, lo); end
  endtask

  task automatic test_div_zero;
    int n, nb;
    issue(1'b1, 32'd5, 32'd0);
    wait_done(n, nb);
    vec++; if (n !== 0) begin err++; $display("FAIL div0_latency: got %0d want 0", n); end
    vec++; if (nb !== 0 || busy !== 1'b0) begin err++; $display("FAIL div0_busy: got cycles=%0d busy=%b want 0 0", nb, busy); end
    vec++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin err++; $display("FAIL div0_result: got %h_%h want 00000005_ffffffff", hi, lo); end
  endtask

  task automatic test_hazard_read;
    logic [W-1:0] a, b, old_hi, old_lo;
    logic [2*W-1:0] exp;
    int n, bad;
    a = $urandom; b = $urandom;
    exp = ref_model(1'b0, a, b);
    old_hi = hi; old_lo = lo;
    issue(1'b0, a, b);
    rd_hilo = 1'b1;
    #1;
    n = 0; bad = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      if (stall !== 1'b1 || hi !== old_hi || lo !== old_lo) bad++;
      @(negedge clk); #1;
      n++;
    end
    vec++; if (bad !== 0 || n !== W) begin err++; $display("FAIL hazard_read_stall: got bad_cycles=%0d cycles=%0d want 0 %0d", bad, n, W); end
    vec++; if (stall !== 1'b0) begin err++; $display("FAIL hazard_read_done_stall: got %b want 0", stall); end
    vec++; if ({hi, lo} !== exp) begin err++; $display("FAIL hazard_read_result: got %h want %h", {hi, lo}, exp); end
    rd_hilo = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a1, b1, a2, b2;
    logic [2*W-1:0] e1, e2;
    int n, nb, bad;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    a2 = $urandom; b2 = $urandom;
    e1 = ref_model(1'b1, a1, b1);
    e2 = ref_model(1'b0, a2, b2);
    issue(1'b1, a1, b1);
    start = 1'b1; op_div = 1'b0; src_a = a2; src_b = b2;
    #1;
    n = 0; bad = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      if (stall !== 1'b1) bad++;
      @(negedge clk); #1;
      n++;
    end
    vec++; if (bad !== 0 || n !== W) begin err++; $display("FAIL b2b_ignored_start: got bad_cycles=%0d cycles=%0d want 0 %0d", bad, n, W); end
    vec++; if ({hi, lo} !== e1 || stall !== 1'b0) begin err++; $display("FAIL b2b_first_result: got %h stall=%b want %h stall=0", {hi, lo}, stall, e1); end
    @(negedge clk);
    start = 1'b0;
    #1;
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL b2b_no_gap: got busy=%b want 1", busy); end
    wait_done(n, nb);
    vec++; if (n !== W || {hi, lo} !== e2) begin err++; $display("FAIL b2b_second_result: got %h after %0d want %h after %0d", {hi, lo}, n, e2, W); end
  endtask

  task automatic test_reset_mid;
    int n, nb;
    issue(1'b0, $urandom | 32'h1, $urandom | 32'h1);
    repeat (9) begin @(negedge clk); #1; end
    rd_hilo = 1'b1;
    rst_n = 1'b0;
    #1;
    vec++; if ({hi, lo} !== '0 || {busy, stall, done} !== 3'b000) begin err++; $display("FAIL reset_mid: got hilo=%h flags=%b want 0 000", {hi, lo}, {busy, stall, done}); end
    rd_hilo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 32'd9, 32'd3);
    wait_done(n, nb);
    vec++; if (lo !== 32'd3 || hi !== 32'd0 || n !== W) begin err++; $display("FAIL reset_mid_div9_3: got hi=%0d lo=%0d after %0d want 0 3 after %0d", hi, lo, n, W); end
  endtask

  task automatic test_random;
    logic div;
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp;
    int n, nb, want_n;
    for (int i = 0; i < 24; i++) begin
      div = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom_range(1, 50);
        default: b = $urandom;
      endcase
      exp = ref_model(div, a, b);
      want_n = (div && b == '0) ? 0 : W;
      issue(div, a, b);
      wait_done(n, nb);
      vec++; if ({hi, lo} !== exp || n !== want_n) begin err++; $display("FAIL random_%0d op_div=%b a=%h b=%h: got %h after %0d want %h after %0d", i, div, a, b, {hi, lo}, n, exp, want_n); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_basic();
    test_div_zero();
    test_hazard_read();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
